rom_fetch_ctrl: RTL and testbench

ROM_FETCH_CTRL -- requirements
Module: rom_fetch_ctrl

---
 rtl/rom_fetch_ctrl.sv | 128 ++++++++++++
 tb/tb_rom_fetch_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch_ctrl.sv
// SPI flash word fetcher: sends READ_CMD, a 24-bit address and four dummy bytes
// through a byte engine, then assembles the last four received bytes big-endian.
module rom_fetch_ctrl #(
    parameter logic [7:0] READ_CMD = 8'h03,
    parameter int         CS_GAP   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [23:0] req_addr,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        cs_n
);

    typedef enum logic [2:0] {IDLE, GAP, SEND, WAIT_RX, DONE} state_t;

    localparam logic [3:0] GAP_INIT = 4'(CS_GAP);

    state_t      state_reg, state_next;
    logic [23:0] addr_reg, addr_next;
    logic [2:0]  idx_reg, idx_next;
    logic [3:0]  gap_reg, gap_next;
    logic [23:0] word_reg, word_next;
    logic [31:0] rsp_data_reg, rsp_data_next;
    logic [7:0]  tx_table [8];

    // Byte sent at each index: opcode, three address bytes, four dummy bytes.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_tx_table
            if (gi == 0) begin : g_cmd
                assign tx_table[gi] = READ_CMD;
            end else if (gi < 4) begin : g_addr
                assign tx_table[gi] = addr_reg[23-8*(gi-1) -: 8];
            end else begin : g_dummy
                assign tx_table[gi] = 8'h00;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            addr_reg     <= 24'h0;
            idx_reg      <= 3'd0;
            gap_reg      <= GAP_INIT;
            word_reg     <= 24'h0;
            rsp_data_reg <= 32'h0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            idx_reg      <= idx_next;
            gap_reg      <= gap_next;
            word_reg     <= word_next;
            rsp_data_reg <= rsp_data_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        idx_next      = idx_reg;
        gap_next      = gap_reg;
        word_next     = word_reg;
        rsp_data_next = rsp_data_reg;
        case (state_reg)
            IDLE: begin
                // The counter is also loaded by reset, so the flash sees cs_n high first.
                if (gap_reg != 4'd0) begin
                    gap_next = gap_reg - 4'd1;
                end else if (req_valid) begin
                    addr_next  = req_addr;
                    idx_next   = 3'd0;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (tx_ready) state_next = WAIT_RX;
            end
            WAIT_RX: begin
                if (rx_valid) begin
                    if (idx_reg[2]) word_next = {word_reg[15:0], rx_data};
                    if (idx_reg == 3'd7) begin
                        rsp_data_next = {word_reg, rx_data};
                        state_next    = DONE;
                    end else begin
                        idx_next   = idx_reg + 3'd1;
                        state_next = SEND;
                    end
                end
            end
            DONE: begin
                // DONE is the first deselect cycle of the gap.
                gap_next   = 4'd0;
                state_next = IDLE;
                if (GAP_INIT > 4'd1) begin
                    gap_next   = GAP_INIT - 4'd1;
                    state_next = GAP;
                end
            end
            GAP: begin
                if (gap_reg <= 4'd1) begin
                    gap_next   = 4'd0;
                    state_next = IDLE;
                end else begin
                    gap_next = gap_reg - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_reg == IDLE) && (gap_reg == 4'd0);
        tx_valid  = (state_reg == SEND);
        tx_data   = (state_reg == SEND) ? tx_table[idx_reg] : 8'h00;
        cs_n      = !((state_reg == SEND) || (state_reg == WAIT_RX));
        rsp_valid = (state_reg == DONE);
        rsp_data  = rsp_data_reg;
    end

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Bench for rom_fetch_ctrl: a behavioural byte-engine/flash model drives random
// handshake timing and checks the byte stream, chip select and returned words.
module tb_rom_fetch_ctrl;

    localparam int CS_GAP = 2;

    logic        clk = 1'b0;
    logic        rst, req_valid, tx_ready, rx_valid;
    logic [23:0] req_addr;
    logic [7:0]  rx_data;
    logic        req_ready, rsp_valid, tx_valid, cs_n;
    logic [31:0] rsp_data;
    logic [7:0]  tx_data;

    int n_checks = 0;
    int n_fail = 0;
    int cs_high_run = 0;

    rom_fetch_ctrl #(.READ_CMD(8'h03), .CS_GAP(CS_GAP)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .cs_n(cs_n)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle and sample just after the edge; tracks the cs_n-high run length.
    task automatic tick();
        @(posedge clk);
        #1;
        if (cs_n) cs_high_run++;
        else cs_high_run = 0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            check_val("idle_cs_n", cs_n, 1'b1);
            tick();
            n++;
        end
        check_val("req_ready", req_ready, 1'b1);
    endtask

    task automatic spur_idle(input logic [31:0] exp_word);
        wait_ready();
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        tick();
        rx_valid = 1'b0;
        check_val("spur_idle_ready", req_ready, 1'b1);
        check_val("spur_idle_cs_n", cs_n, 1'b1);
        check_val("spur_idle_rsp", rsp_data, exp_word);
    endtask

    task automatic run_fetch(input logic [23:0] addr, input logic [31:0] word,
                             input int stall_idx, input int stall_len, input bit fast,
                             input bit spur, input int abort_at, input bit held,
                             input bit chain, input logic [23:0] next_addr);
        logic [7:0] exp_tx [8];
        logic [7:0] rx_b [8];
        int ntx, nrx, cyc, stall_left, rx_delay, n;
        bit spur_done, finished, hs, rxp;
        exp_tx[0] = 8'h03;
        exp_tx[1] = addr[23:16];
        exp_tx[2] = addr[15:8];
        exp_tx[3] = addr[7:0];
        for (int i = 4; i < 8; i++) exp_tx[i] = 8'h00;
        for (int i = 0; i < 4; i++) rx_b[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) rx_b[4+i] = word[31-8*i -: 8];

        wait_ready();
        if (held) check_val("cs_gap_exact", cs_high_run, CS_GAP + 1);
        else      check_val("cs_gap_min", 32'(cs_high_run >= CS_GAP + 1), 1);
        req_valid = 1'b1;
        req_addr  = addr;
        tx_ready  = 1'b0;
        rx_valid  = 1'b0;
        tick();
        if (chain) req_addr = next_addr;
        else req_valid = 1'b0;

        ntx = 0; nrx = 0; cyc = 0; stall_left = stall_len;
        rx_delay = fast ? 0 : $urandom_range(0, 3);
        spur_done = 1'b0; finished = 1'b0;
        while (!finished && cyc < 400) begin
            if (nrx == 8) begin
                check_val("rsp_valid", rsp_valid, 1'b1);
                check_val("rsp_data", rsp_data, word);
                check_val("done_cs_n", cs_n, 1'b1);
                if (fast) check_val("latency", cyc, 16 + stall_len);
                finished = 1'b1;
            end else begin
                check_val("active_cs_n", cs_n, 1'b0);
                check_val("no_rsp", rsp_valid, 1'b0);
                check_val("tx_valid", tx_valid, 32'(ntx == nrx));
                if (tx_valid && ntx < 8) check_val($sformatf("tx_byte%0d", ntx), tx_data, exp_tx[ntx]);
                if (abort_at >= 0 && nrx == abort_at) begin
                    rst = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0;
                    tick();
                    rst = 1'b0;
                    check_val("abort_cs_n", cs_n, 1'b1);
                    check_val("abort_rsp_valid", rsp_valid, 1'b0);
                    check_val("abort_rsp_data", rsp_data, 32'h0);
                    check_val("abort_tx_valid", tx_valid, 1'b0);
                    n = 0;
                    while (!req_ready && n < 20) begin
                        check_val("abort_no_rsp", rsp_valid, 1'b0);
                        tick();
                        n++;
                    end
                    check_val("abort_gap", n, CS_GAP);
                    repeat (3) tick();
                    check_val("abort_no_replay", cs_n, 1'b1);
                    return;
                end
                tx_ready = 1'b0; hs = 1'b0; rxp = 1'b0;
                if (ntx == nrx) begin
                    if (ntx == stall_idx && stall_left > 0) stall_left--;
                    else tx_ready = fast ? 1'b1 : ($urandom_range(0, 3) != 0);
                    hs = tx_ready && tx_valid;
                    if (spur && !spur_done && ntx == 2) begin
                        rx_valid = 1'b1; rx_data = 8'hEE; spur_done = 1'b1;
                    end
                end else if (rx_delay == 0) begin
                    rx_valid = 1'b1; rx_data = rx_b[nrx]; rxp = 1'b1;
                    rx_delay = fast ? 0 : $urandom_range(0, 3);
                end else begin
                    rx_delay--;
                end
                tick();
                rx_valid = 1'b0;
                cyc++;
                if (hs) ntx++;
                if (rxp) nrx++;
            end
        end
        check_val("fetch_done", finished, 1'b1);
        tx_ready = 1'b0;
        tick();
        check_val("rsp_single", rsp_valid, 1'b0);
        check_val("rsp_hold", rsp_data, word);
    endtask

    initial begin
        int n;
        logic [23:0] a;
        logic [31:0] w;
        rst = 1'b1; req_valid = 1'b0; req_addr = 24'h0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) tick();
        check_val("rst_cs_n", cs_n, 1'b1);
        check_val("rst_tx_valid", tx_valid, 1'b0);
        check_val("rst_rsp_valid", rsp_valid, 1'b0);
        check_val("rst_req_ready", req_ready, 1'b0);
        check_val("rst_rsp_data", rsp_data, 32'h0);
        check_val("rst_tx_data", tx_data, 8'h00);
        rst = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        check_val("rst_gap", n, CS_GAP);

        run_fetch(24'h012345, 32'hAABBCCDD, -1, 0, 1'b1, 1'b0, -1, 1'b0, 1'b0, 24'h0);
        spur_idle(32'hAABBCCDD);
        run_fetch(24'h012345, 32'hAABBCCDD, 2, 5, 1'b1, 1'b0, -1, 1'b0, 1'b0, 24'h0);
        run_fetch(24'h0A0B0C, 32'h11223344, -1, 0, 1'b1, 1'b1, -1, 1'b0, 1'b0, 24'h0);
        run_fetch(24'hFFFFFF, 32'hCAFEF00D, -1, 0, 1'b1, 1'b0, -1, 1'b0, 1'b0, 24'h0);
        run_fetch(24'h100200, 32'h01020304, -1, 0, 1'b1, 1'b0, -1, 1'b0, 1'b1, 24'h300400);
        run_fetch(24'h300400, 32'h05060708, -1, 0, 1'b1, 1'b0, -1, 1'b1, 1'b0, 24'h0);
        req_valid = 1'b0;

        for (int t = 0; t < 25; t++) begin
            a = 24'($urandom);
            w = $urandom;
            run_fetch(a, w, $urandom_range(0, 7), $urandom_range(0, 4), 1'b0,
                      1'($urandom_range(0, 1)), -1, 1'b0, 1'b0, 24'h0);
        end

        run_fetch(24'h0055AA, 32'h99887766, -1, 0, 1'b1, 1'b0, 6, 1'b0, 1'b0, 24'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
